// File: rtl/gpu_pkg.sv
// Shared types and constants for the rectangle hit stage: table layout,
// rectangle record, load FSM states and the table field-write helper.
package gpu_pkg;

  localparam int RECT_COUNT     = 64;
  localparam int COORD_WIDTH    = 16;
  localparam int COLOR_WIDTH    = 6;
  localparam int WORDS_PER_RECT = 5;
  localparam int FIELD_WIDTH    = 3;

  localparam logic [FIELD_WIDTH-1:0] FIELD_X     = 3'd0;
  localparam logic [FIELD_WIDTH-1:0] FIELD_Y     = 3'd1;
  localparam logic [FIELD_WIDTH-1:0] FIELD_W     = 3'd2;
  localparam logic [FIELD_WIDTH-1:0] FIELD_H     = 3'd3;
  localparam logic [FIELD_WIDTH-1:0] FIELD_COLOR = 3'd4;

  typedef struct packed {
    logic [COORD_WIDTH-1:0] x;
    logic [COORD_WIDTH-1:0] y;
    logic [COORD_WIDTH-1:0] w;
    logic [COORD_WIDTH-1:0] h;
    logic [COLOR_WIDTH-1:0] color;
  } rect_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_DRAIN = 2'd2
  } load_state_t;

  // Returns the record with one field replaced by a memory word; the colour
  // keeps only its low COLOR_WIDTH bits.
  function automatic rect_t rect_set_field(input rect_t r,
                                           input logic [FIELD_WIDTH-1:0] field,
                                           input logic [COORD_WIDTH-1:0] word);
    rect_t n;
    n = r;
    case (field)
      FIELD_X:     n.x     = word;
      FIELD_Y:     n.y     = word;
      FIELD_W:     n.w     = word;
      FIELD_H:     n.h     = word;
      FIELD_COLOR: n.color = word[COLOR_WIDTH-1:0];
      default:     n       = r;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/rect_hit_cell.sv
// One rectangle's hit comparator with its registered hit flag and colour.
// End coordinates are formed one bit wider so x+w never wraps.
module rect_hit_cell
  import gpu_pkg::*;
(
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   i_pixel_valid,
  input  logic [COORD_WIDTH-1:0] i_x,
  input  logic [COORD_WIDTH-1:0] i_y,
  input  rect_t                  i_rect,
  output logic                   o_hit,
  output logic [COLOR_WIDTH-1:0] o_color
);

  logic [COORD_WIDTH:0] w_x_end;
  logic [COORD_WIDTH:0] w_y_end;
  logic                 w_in_x;
  logic                 w_in_y;

  // A zero width or height makes the half-open range empty, so no hit.
  assign w_x_end = {1'b0, i_rect.x} + {1'b0, i_rect.w};
  assign w_y_end = {1'b0, i_rect.y} + {1'b0, i_rect.h};
  assign w_in_x  = (i_x >= i_rect.x) && ({1'b0, i_x} < w_x_end);
  assign w_in_y  = (i_y >= i_rect.y) && ({1'b0, i_y} < w_y_end);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      o_hit   <= 1'b0;
      o_color <= {COLOR_WIDTH{1'b0}};
    end else begin
      o_hit   <= i_pixel_valid & w_in_x & w_in_y;
      o_color <= i_rect.color;
    end
  end

endmodule

// File: rtl/rect_hit_stage.sv
// Rectangle hit stage: loads the rectangle table during vblank and produces
// registered per-rectangle hit flags/colours each pixel. Option: RECT_SHADOW_EN.
module rect_hit_stage #(
  parameter int RECT_COUNT  = gpu_pkg::RECT_COUNT,
  parameter int COORD_WIDTH = gpu_pkg::COORD_WIDTH,
  parameter int COLOR_WIDTH = gpu_pkg::COLOR_WIDTH,
  parameter int ADDR_WIDTH  = 13,
  parameter int BASE_ADDR   = 0
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   frame_start,
  output logic                   mem_rd_en,
  output logic [ADDR_WIDTH-1:0]  mem_addr,
  input  logic [COORD_WIDTH-1:0] mem_data,
  output logic                   busy,
  output logic                   load_done,
  input  logic                   pixel_valid,
  input  logic [COORD_WIDTH-1:0] x,
  input  logic [COORD_WIDTH-1:0] y,
  output logic                   out_valid,
  output logic [RECT_COUNT-1:0]  flags_out,
  output logic [COLOR_WIDTH-1:0] data_out [RECT_COUNT]
);
  import gpu_pkg::*;

  localparam int CNT_W = $clog2(WORDS_PER_RECT * RECT_COUNT);
  localparam int IDX_W = $clog2(RECT_COUNT);

  localparam logic [CNT_W-1:0]       LAST_CNT  = CNT_W'(WORDS_PER_RECT * RECT_COUNT - 1);
  localparam logic [CNT_W-1:0]       CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [IDX_W-1:0]       IDX_ONE   = {{(IDX_W-1){1'b0}}, 1'b1};
  localparam logic [ADDR_WIDTH-1:0]  ADDR_ONE  = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [ADDR_WIDTH-1:0]  ADDR_BASE = ADDR_WIDTH'(BASE_ADDR);
  localparam logic [FIELD_WIDTH-1:0] FIELD_ONE = 3'd1;

  load_state_t             r_state;
  logic                    r_busy;
  logic                    r_load_done;
  logic                    r_mem_rd_en;
  logic [ADDR_WIDTH-1:0]   r_mem_addr;
  logic [CNT_W-1:0]        r_cnt;
  logic [IDX_W-1:0]        r_rd_rect;
  logic [FIELD_WIDTH-1:0]  r_rd_field;
  logic                    r_wr_en;
  logic [IDX_W-1:0]        r_wr_rect;
  logic [FIELD_WIDTH-1:0]  r_wr_field;
  logic                    r_out_valid;
  rect_t                   r_active [RECT_COUNT];

  // Read sequencer: r_rd_rect/r_rd_field track the word being addressed and
  // are delayed one cycle into r_wr_* to match the memory read latency.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= ST_IDLE;
      r_busy      <= 1'b0;
      r_load_done <= 1'b0;
      r_mem_rd_en <= 1'b0;
      r_mem_addr  <= ADDR_BASE;
      r_cnt       <= {CNT_W{1'b0}};
      r_rd_rect   <= {IDX_W{1'b0}};
      r_rd_field  <= FIELD_X;
      r_wr_en     <= 1'b0;
      r_wr_rect   <= {IDX_W{1'b0}};
      r_wr_field  <= FIELD_X;
    end else begin
      r_load_done <= 1'b0;
      r_wr_en     <= r_mem_rd_en;
      r_wr_rect   <= r_rd_rect;
      r_wr_field  <= r_rd_field;
      case (r_state)
        ST_IDLE: begin
          if (frame_start) begin
            r_state     <= ST_LOAD;
            r_busy      <= 1'b1;
            r_mem_rd_en <= 1'b1;
            r_mem_addr  <= ADDR_BASE;
            r_cnt       <= {CNT_W{1'b0}};
            r_rd_rect   <= {IDX_W{1'b0}};
            r_rd_field  <= FIELD_X;
          end
        end
        ST_LOAD: begin
          if (r_cnt == LAST_CNT) begin
            r_state     <= ST_DRAIN;
            r_mem_rd_en <= 1'b0;
            r_mem_addr  <= ADDR_BASE;
          end else begin
            r_cnt      <= r_cnt + CNT_ONE;
            r_mem_addr <= r_mem_addr + ADDR_ONE;
            if (r_rd_field == FIELD_COLOR) begin
              r_rd_field <= FIELD_X;
              r_rd_rect  <= r_rd_rect + IDX_ONE;
            end else begin
              r_rd_field <= r_rd_field + FIELD_ONE;
            end
          end
        end
        ST_DRAIN: begin
          r_state     <= ST_IDLE;
          r_busy      <= 1'b0;
          r_load_done <= 1'b1;
        end
        default: begin
          r_state     <= ST_IDLE;
          r_busy      <= 1'b0;
          r_mem_rd_en <= 1'b0;
          r_mem_addr  <= ADDR_BASE;
        end
      endcase
    end
  end

`ifdef RECT_SHADOW_EN
  rect_t r_shadow [RECT_COUNT];

  // Loads fill the shadow; pixels keep using the previous table meanwhile.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < RECT_COUNT; i++) begin
        r_shadow[i] <= '0;
      end
    end else if (r_wr_en) begin
      r_shadow[r_wr_rect] <= rect_set_field(r_shadow[r_wr_rect], r_wr_field, mem_data);
    end
  end

  // Commit on the DRAIN edge, merging the final word so it is not lost.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < RECT_COUNT; i++) begin
        r_active[i] <= '0;
      end
    end else if (r_state == ST_DRAIN) begin
      for (int i = 0; i < RECT_COUNT; i++) begin
        if (r_wr_en && (r_wr_rect == IDX_W'(i))) begin
          r_active[i] <= rect_set_field(r_shadow[i], r_wr_field, mem_data);
        end else begin
          r_active[i] <= r_shadow[i];
        end
      end
    end
  end
`else
  // Loads write the active table directly.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < RECT_COUNT; i++) begin
        r_active[i] <= '0;
      end
    end else if (r_wr_en) begin
      r_active[r_wr_rect] <= rect_set_field(r_active[r_wr_rect], r_wr_field, mem_data);
    end
  end
`endif

  // Output qualifier tracks pixel_valid with the one-cycle hit latency.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_out_valid <= 1'b0;
    end else begin
      r_out_valid <= pixel_valid;
    end
  end

  for (genvar g = 0; g < RECT_COUNT; g++) begin : g_cell
    rect_hit_cell u_cell (
      .clk           (clk),
      .reset_n       (reset_n),
      .i_pixel_valid (pixel_valid),
      .i_x           (x),
      .i_y           (y),
      .i_rect        (r_active[g]),
      .o_hit         (flags_out[g]),
      .o_color       (data_out[g])
    );
  end

  assign mem_rd_en = r_mem_rd_en;
  assign mem_addr  = r_mem_addr;
  assign busy      = r_busy;
  assign load_done = r_load_done;
  assign out_valid = r_out_valid;

endmodule

// File: tb/tb_rect_hit_stage.sv
// Directed self-checking bench for rect_hit_stage with a synchronous memory
// model; the shadow-table scenario follows RECT_SHADOW_EN.
module tb_rect_hit_stage;

  localparam int NR = 64;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        frame_start = 1'b0;
  logic        pixel_valid = 1'b0;
  logic [15:0] x = 16'd0;
  logic [15:0] y = 16'd0;
  logic        mem_rd_en;
  logic [12:0] mem_addr;
  logic [15:0] mem_data = 16'd0;
  logic        busy;
  logic        load_done;
  logic        out_valid;
  logic [63:0] flags_out;
  logic [5:0]  data_out [NR];

  logic [15:0] mem [8192];

  int tests = 0;
  int fails = 0;

  int cyc = 0;
  int fs_cyc = -1;
  int exp_addr = 0;
  int rd_total = 0;
  int addr_err = 0;
  int last_rd_cyc = -1;
  int busy_total = 0;
  int done_total = 0;
  int done_cyc = -1;

  rect_hit_stage dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .frame_start (frame_start),
    .mem_rd_en   (mem_rd_en),
    .mem_addr    (mem_addr),
    .mem_data    (mem_data),
    .busy        (busy),
    .load_done   (load_done),
    .pixel_valid (pixel_valid),
    .x           (x),
    .y           (y),
    .out_valid   (out_valid),
    .flags_out   (flags_out),
    .data_out    (data_out)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_rd_en) mem_data <= mem[mem_addr];
  end

  always @(posedge clk) begin
    if (frame_start && !busy && reset_n) begin
      fs_cyc   = cyc;
      exp_addr = 0;
    end
    if (mem_rd_en) begin
      rd_total++;
      if (mem_addr !== exp_addr[12:0]) addr_err++;
      exp_addr++;
      last_rd_cyc = cyc;
    end
    if (busy) busy_total++;
    if (load_done) begin
      done_total++;
      done_cyc = cyc;
    end
    cyc++;
  end

  task automatic set_rect(input int i, input logic [15:0] rx, ry, rw, rh, rc);
    mem[5*i+0] = rx;
    mem[5*i+1] = ry;
    mem[5*i+2] = rw;
    mem[5*i+3] = rh;
    mem[5*i+4] = rc;
  endtask

  task automatic apply_pixel(input logic [15:0] px, py, input logic v);
    @(negedge clk);
    pixel_valid = v;
    x = px;
    y = py;
    @(negedge clk);
  endtask

  task automatic run_load(input int second_fs_at,
                          output int n_rd, output int n_busy, output int n_done,
                          output int t_fs, output int t_last, output int t_done,
                          output bit timed_out);
    int rd0, b0, d0;
    rd0 = rd_total;
    b0  = busy_total;
    d0  = done_total;
    @(negedge clk);
    frame_start = 1'b1;
    @(negedge clk);
    frame_start = 1'b0;
    timed_out = 1'b1;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      frame_start = (i == second_fs_at);
      if (done_total != d0) begin
        timed_out = 1'b0;
        break;
      end
    end
    frame_start = 1'b0;
    repeat (4) @(negedge clk);
    n_rd   = rd_total - rd0;
    n_busy = busy_total - b0;
    n_done = done_total - d0;
    t_fs   = fs_cyc;
    t_last = last_rd_cyc;
    t_done = done_cyc;
  endtask

  task automatic test_reset();
    int nz;
    reset_n = 1'b0;
    pixel_valid = 1'b1;
    x = 16'd10;
    y = 16'd10;
    repeat (3) @(negedge clk);
    tests++;
    if (flags_out !== 64'd0 || out_valid !== 1'b0) begin
      fails++;
      $display("FAIL reset_hold flags=%h out_valid=%b required flags=0 out_valid=0", flags_out, out_valid);
    end
    reset_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      nz = 0;
      for (int i = 0; i < NR; i++) if (data_out[i] !== 6'd0) nz++;
      tests++;
      if (flags_out !== 64'd0 || nz !== 0 || out_valid !== 1'b1) begin
        fails++;
        $display("FAIL reset_idle flags=%h nonzero_colours=%0d out_valid=%b required 0/0/1", flags_out, nz, out_valid);
      end
    end
    tests++;
    if (rd_total !== 0 || busy !== 1'b0) begin
      fails++;
      $display("FAIL reset_no_reads reads=%0d busy=%b required 0/0", rd_total, busy);
    end
  endtask

  task automatic test_full_load();
    int n_rd, n_busy, n_done, t_fs, t_last, t_done;
    bit to;
    run_load(-1, n_rd, n_busy, n_done, t_fs, t_last, t_done, to);
    tests++;
    if (to || n_done !== 1) begin
      fails++;
      $display("FAIL load_done_count timeout=%0d dones=%0d required 0/1", to, n_done);
    end
    tests++;
    if (n_rd !== 320 || addr_err !== 0) begin
      fails++;
      $display("FAIL load_reads reads=%0d addr_errors=%0d required 320/0", n_rd, addr_err);
    end
    tests++;
    if (t_last !== t_fs + 320 || t_done !== t_fs + 322) begin
      fails++;
      $display("FAIL load_timing last_read=T+%0d done=T+%0d required T+320/T+322", t_last - t_fs, t_done - t_fs);
    end
    tests++;
    if (n_busy !== 321) begin
      fails++;
      $display("FAIL load_busy busy_cycles=%0d required 321", n_busy);
    end
    apply_pixel(16'd5, 16'd5, 1'b1);
    tests++;
    if (flags_out !== 64'd1 || data_out[0] !== 6'h2A || out_valid !== 1'b1) begin
      fails++;
      $display("FAIL hit_5_5 flags=%h colour=%h valid=%b required 1/2a/1", flags_out, data_out[0], out_valid);
    end
    apply_pixel(16'd5, 16'd5, 1'b0);
    tests++;
    if (flags_out !== 64'd0 || out_valid !== 1'b0) begin
      fails++;
      $display("FAIL invalid_pixel flags=%h valid=%b required 0/0", flags_out, out_valid);
    end
  endtask

  task automatic test_boundaries();
    logic [15:0] px [4] = '{16'd14, 16'd15, 16'd5, 16'd4};
    logic [15:0] py [4] = '{16'd14, 16'd5, 16'd15, 16'd5};
    logic [63:0] ef [4] = '{64'd1, 64'd0, 64'd0, 64'd0};
    for (int k = 0; k < 4; k++) begin
      apply_pixel(px[k], py[k], 1'b1);
      tests++;
      if (flags_out !== ef[k]) begin
        fails++;
        $display("FAIL boundary_%0d_%0d flags=%h required %h", px[k], py[k], flags_out, ef[k]);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] px [5] = '{16'd5, 16'd4, 16'd14, 16'd14, 16'd10};
    logic [15:0] py [5] = '{16'd5, 16'd5, 16'd14, 16'd15, 16'd7};
    logic        pv [5] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
    logic [63:0] ef [5] = '{64'd1, 64'd0, 64'd0, 64'd0, 64'd1};
    for (int k = 0; k <= 5; k++) begin
      @(negedge clk);
      if (k > 0) begin
        tests++;
        if (flags_out !== ef[k-1] || out_valid !== pv[k-1]) begin
          fails++;
          $display("FAIL b2b_%0d flags=%h valid=%b required %h/%b", k-1, flags_out, out_valid, ef[k-1], pv[k-1]);
        end
      end
      if (k < 5) begin
        pixel_valid = pv[k];
        x = px[k];
        y = py[k];
      end
    end
  endtask

  task automatic test_overflow();
    int n_rd, n_busy, n_done, t_fs, t_last, t_done;
    bit to;
    set_rect(1, 16'hFFF0, 16'h0000, 16'h0020, 16'h0001, 16'h0003);
    run_load(-1, n_rd, n_busy, n_done, t_fs, t_last, t_done, to);
    tests++;
    if (to || n_done !== 1) begin
      fails++;
      $display("FAIL overflow_load timeout=%0d dones=%0d required 0/1", to, n_done);
    end
    apply_pixel(16'hFFFF, 16'h0000, 1'b1);
    tests++;
    if (flags_out !== 64'd2 || data_out[1] !== 6'd3) begin
      fails++;
      $display("FAIL overflow_ffff flags=%h colour=%h required 2/03", flags_out, data_out[1]);
    end
    apply_pixel(16'h000F, 16'h0000, 1'b1);
    tests++;
    if (flags_out !== 64'd0) begin
      fails++;
      $display("FAIL overflow_wrap flags=%h required 0", flags_out);
    end
    apply_pixel(16'hFFFF, 16'h0001, 1'b1);
    tests++;
    if (flags_out !== 64'd0) begin
      fails++;
      $display("FAIL overflow_row1 flags=%h required 0", flags_out);
    end
  endtask

  task automatic test_reset_mid_load();
    int d0;
    int n_rd, n_busy, n_done, t_fs, t_last, t_done;
    bit to;
    @(negedge clk);
    frame_start = 1'b1;
    @(negedge clk);
    frame_start = 1'b0;
    repeat (99) @(negedge clk);
    reset_n = 1'b0;
    #1;
    tests++;
    if (busy !== 1'b0 || mem_rd_en !== 1'b0 || load_done !== 1'b0 || flags_out !== 64'd0) begin
      fails++;
      $display("FAIL midload_reset busy=%b rd_en=%b done=%b flags=%h required all 0", busy, mem_rd_en, load_done, flags_out);
    end
    d0 = done_total;
    @(negedge clk);
    reset_n = 1'b1;
    pixel_valid = 1'b1;
    x = 16'd5;
    y = 16'd5;
    repeat (400) @(negedge clk);
    tests++;
    if (done_total !== d0 || flags_out !== 64'd0 || busy !== 1'b0) begin
      fails++;
      $display("FAIL midload_after dones=%0d flags=%h busy=%b required 0/0/0", done_total - d0, flags_out, busy);
    end
    run_load(50, n_rd, n_busy, n_done, t_fs, t_last, t_done, to);
    tests++;
    if (to || n_rd !== 320 || n_done !== 1 || t_done !== t_fs + 322) begin
      fails++;
      $display("FAIL ignored_frame_start timeout=%0d reads=%0d dones=%0d done=T+%0d required 0/320/1/T+322", to, n_rd, n_done, t_done - t_fs);
    end
  endtask

  task automatic test_shadow();
    mem[2] = 16'd0;
    set_rect(2, 16'd5, 16'd5, 16'd1, 16'd1, 16'h0015);
    pixel_valid = 1'b1;
    x = 16'd5;
    y = 16'd5;
`ifdef RECT_SHADOW_EN
    @(negedge clk);
    frame_start = 1'b1;
    @(negedge clk);
    frame_start = 1'b0;
    for (int e = 1; e <= 330; e++) begin
      @(negedge clk);
      tests++;
      if (e <= 321) begin
        if (flags_out !== 64'd1 || data_out[2] !== 6'd0) begin
          fails++;
          $display("FAIL shadow_old T+%0d flags=%h colour2=%h required 1/00", e, flags_out, data_out[2]);
        end
      end else begin
        if (flags_out !== 64'd4 || data_out[2] !== 6'h15) begin
          fails++;
          $display("FAIL shadow_new T+%0d flags=%h colour2=%h required 4/15", e, flags_out, data_out[2]);
        end
      end
      if (e == 320 || e == 321) begin
        tests++;
        if (load_done !== (e == 321)) begin
          fails++;
          $display("FAIL shadow_done T+%0d load_done=%b required %b", e + 1, load_done, (e == 321));
        end
      end
    end
`else
    begin
      int n_rd, n_busy, n_done, t_fs, t_last, t_done;
      bit to;
      run_load(-1, n_rd, n_busy, n_done, t_fs, t_last, t_done, to);
      @(negedge clk);
      tests++;
      if (to || flags_out !== 64'd4 || data_out[2] !== 6'h15) begin
        fails++;
        $display("FAIL table_b timeout=%0d flags=%h colour2=%h required 0/4/15", to, flags_out, data_out[2]);
      end
    end
`endif
  endtask

  initial begin
    for (int i = 0; i < 8192; i++) mem[i] = 16'd0;
    set_rect(0, 16'd5, 16'd5, 16'd10, 16'd10, 16'h002A);
    test_reset();
    test_full_load();
    test_boundaries();
    test_back_to_back();
    test_overflow();
    test_reset_mid_load();
    test_shadow();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
